// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - shared types and constants for the IQ sample path
package sdr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5A5;

  localparam int HDR_SYNC_MSB = 31;
  localparam int HDR_SYNC_LSB = 16;
  localparam int HDR_SEQ_MSB  = 15;
  localparam int HDR_SEQ_LSB  = 0;

  function automatic int clog2_c(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_test_pattern_gen.sv
// rtl/iq_test_pattern_gen.sv - 8-bit ramp source, restarted at every frame start
module iq_test_pattern_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       advance,
  output logic [7:0] ramp
);

  logic [7:0] cnt;

  // The pair that opens a frame sees 0 without waiting for the register.
  assign ramp = frame_start ? 8'd0 : cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (advance) begin
      cnt <= ramp + 8'd1;
    end
  end

endmodule

// File: rtl/iq_frame_packer.sv
// rtl/iq_frame_packer.sv - packs I/Q pairs into framed 32-bit FIFO words; IQ_PACKER_TEST_PATTERN_EN adds a ramp test mode
module iq_frame_packer
  import sdr_pkg::*;
#(
  parameter int          FRAME_WORDS = 1024,
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef IQ_PACKER_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  input  logic                 en,
  input  logic                 sample_valid,
  input  logic [7:0]           sample_i,
  input  logic [7:0]           sample_q,
  input  logic                 fifo_full,
  output logic [31:0]          fifo_wdata,
  output logic                 fifo_wr,
  output logic                 frame_active,
  output logic [CNT_WIDTH-1:0] seq_num,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam int PW = clog2_c(2 * FRAME_WORDS);

  state_t        state;
  logic [PW-1:0] pair_cnt;
  logic [15:0]   hold;
  logic [7:0]    cur_i;
  logic [7:0]    cur_q;
  logic [31:0]   header;
  logic          last_pair;
  logic          frame_start;

  assign frame_start = (state == IDLE) && en;
  assign last_pair   = &pair_cnt;

`ifdef IQ_PACKER_TEST_PATTERN_EN
  logic [7:0] ramp;

  iq_test_pattern_gen u_pattern (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .advance     (sample_valid),
    .ramp        (ramp)
  );

  assign cur_i = test_mode ? ramp  : sample_i;
  assign cur_q = test_mode ? ~ramp : sample_q;
`else
  assign cur_i = sample_i;
  assign cur_q = sample_q;
`endif

  always_comb begin
    header = '0;
    header[HDR_SYNC_MSB:HDR_SYNC_LSB] = SYNC_WORD;
    header[HDR_SEQ_MSB:HDR_SEQ_LSB]   = 16'(seq_num);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pair_cnt     <= '0;
      hold         <= '0;
      fifo_wr      <= 1'b0;
      fifo_wdata   <= '0;
      frame_active <= 1'b0;
      seq_num      <= '0;
      drop_count   <= '0;
    end else begin
      fifo_wr <= 1'b0;
      if (sample_valid) begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              pair_cnt <= PW'(1);
              if (!fifo_full) begin
                fifo_wr      <= 1'b1;
                fifo_wdata   <= header;
                hold         <= {cur_q, cur_i};
                frame_active <= 1'b1;
                state        <= PAYLOAD;
              end else begin
                drop_count <= (&drop_count) ? drop_count : drop_count + 1'b1;
                state      <= DROP;
              end
            end
          end
          PAYLOAD: begin
            pair_cnt <= pair_cnt + 1'b1;
            if (!pair_cnt[0]) begin
              hold <= {cur_q, cur_i};
            end else if (!fifo_full) begin
              fifo_wr    <= 1'b1;
              fifo_wdata <= {cur_q, cur_i, hold};
            end else begin
              drop_count   <= (&drop_count) ? drop_count : drop_count + 1'b1;
              frame_active <= 1'b0;
              state        <= DROP;
            end
            // The last pair closes the frame even if its own word was dropped.
            if (last_pair) begin
              seq_num      <= seq_num + 1'b1;
              frame_active <= 1'b0;
              state        <= IDLE;
            end
          end
          DROP: begin
            pair_cnt <= pair_cnt + 1'b1;
            if (last_pair) begin
              seq_num <= seq_num + 1'b1;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iq_frame_packer.sv
// tb/tb_iq_frame_packer.sv - randomized and directed checks of iq_frame_packer against a frame-level model
module tb_iq_frame_packer;

  localparam int FW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        sample_valid;
  logic [7:0]  sample_i;
  logic [7:0]  sample_q;
  logic        fifo_full;
  logic [31:0] fifo_wdata;
  logic        fifo_wr;
  logic        frame_active;
  logic [15:0] seq_num;
  logic [15:0] drop_count;
`ifdef IQ_PACKER_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  iq_frame_packer #(.FRAME_WORDS(FW)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef IQ_PACKER_TEST_PATTERN_EN
    .test_mode    (test_mode),
`endif
    .en           (en),
    .sample_valid (sample_valid),
    .sample_i     (sample_i),
    .sample_q     (sample_q),
    .fifo_full    (fifo_full),
    .fifo_wdata   (fifo_wdata),
    .fifo_wr      (fifo_wr),
    .frame_active (frame_active),
    .seq_num      (seq_num),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: position within the frame and whether it is being dropped.
  int          pos = 0;
  bit          dropping = 1'b0;
  logic [15:0] held = '0;
  logic        m_wr = 1'b0;
  logic [31:0] m_wdata = '0;
  logic        m_active = 1'b0;
  logic [15:0] m_seq = '0;
  logic [15:0] m_drop = '0;

  always @(posedge clk) begin
    m_wr = 1'b0;
    if (reset) begin
      pos = 0; dropping = 1'b0; held = '0;
      m_wdata = '0; m_active = 1'b0; m_seq = '0; m_drop = '0;
    end else if (sample_valid) begin
      if (pos == 0) begin
        if (en) begin
          if (!fifo_full) begin
            m_wr = 1'b1; m_wdata = {16'hA5A5, m_seq};
            held = {sample_q, sample_i}; m_active = 1'b1; dropping = 1'b0;
          end else begin
            dropping = 1'b1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          end
          pos = 1;
        end
      end else begin
        if (!dropping) begin
          if (pos % 2 == 0) held = {sample_q, sample_i};
          else if (!fifo_full) begin
            m_wr = 1'b1; m_wdata = {sample_q, sample_i, held};
          end else begin
            dropping = 1'b1; m_active = 1'b0;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          end
        end
        pos++;
        if (pos == 2 * FW) begin
          pos = 0; m_seq = m_seq + 16'd1; m_active = 1'b0;
        end
      end
    end
  end

  logic [31:0] wlog[$];

  always @(negedge clk) begin
    if (fifo_wr === 1'b1) wlog.push_back(fifo_wdata);
    if (chk_en) begin
      check("fifo_wr", {31'd0, fifo_wr}, {31'd0, m_wr});
      check("fifo_wdata", fifo_wdata, m_wdata);
      check("frame_active", {31'd0, frame_active}, {31'd0, m_active});
      check("seq_num", {16'd0, seq_num}, {16'd0, m_seq});
      check("drop_count", {16'd0, drop_count}, {16'd0, m_drop});
    end
  end

  task automatic send_pair(input logic [7:0] i, input logic [7:0] q, input logic e, input logic full);
    @(posedge clk); #2;
    sample_valid = 1'b1; sample_i = i; sample_q = q; en = e; fifo_full = full;
  endtask

  task automatic drain();
    @(posedge clk); #2;
    sample_valid = 1'b0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1; sample_valid = 1'b0; fifo_full = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    wlog.delete();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sample_valid = 1'b0;
    sample_i = '0; sample_q = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); #1;
    check("reset_wr", {31'd0, fifo_wr}, 32'd0);
    check("reset_wdata", fifo_wdata, 32'd0);
    check("reset_seq", {16'd0, seq_num}, 32'd0);
    check("reset_drop", {16'd0, drop_count}, 32'd0);
    check("reset_active", {31'd0, frame_active}, 32'd0);

    // Two full frames, no backpressure.
    wlog.delete();
    for (int n = 0; n < 16; n++) send_pair(8'(n), 8'(8'h80 + n), 1'b1, 1'b0);
    drain();
    check("a_count", wlog.size(), 32'd10);
    if (wlog.size() >= 6) begin
      check("a_hdr0", wlog[0], 32'hA5A50000);
      check("a_w1", wlog[1], 32'h81018000);
      check("a_w2", wlog[2], 32'h83038202);
      check("a_w3", wlog[3], 32'h85058404);
      check("a_w4", wlog[4], 32'h87078606);
      check("a_hdr1", wlog[5], 32'hA5A50001);
    end

    // Full on the cycle of the third payload word.
    do_reset();
    for (int n = 0; n < 16; n++) send_pair(8'(n), 8'(8'h80 + n), 1'b1, n == 5);
    drain();
    check("b_count", wlog.size(), 32'd8);
    check("b_drop", {16'd0, drop_count}, 32'd1);
    if (wlog.size() >= 4) check("b_hdr1", wlog[3], 32'hA5A50001);

    // Full on the first pair of a frame.
    do_reset();
    for (int n = 0; n < 16; n++) send_pair(8'(n), 8'(8'h80 + n), 1'b1, n == 0);
    drain();
    check("c_count", wlog.size(), 32'd5);
    check("c_drop", {16'd0, drop_count}, 32'd1);
    if (wlog.size() >= 1) check("c_hdr", wlog[0], 32'hA5A50001);

    // en low for ten pairs, then high.
    do_reset();
    for (int n = 0; n < 18; n++) send_pair(8'(n), 8'(8'h80 + n), n >= 10, 1'b0);
    drain();
    check("d_count", wlog.size(), 32'd5);
    if (wlog.size() >= 2) begin
      check("d_hdr", wlog[0], 32'hA5A50000);
      check("d_w1", wlog[1], 32'h8B0B8A0A);
    end

    // Reset after five pairs of a frame.
    do_reset();
    for (int n = 0; n < 5; n++) send_pair(8'(n), 8'(8'h80 + n), 1'b1, 1'b0);
    do_reset();
    @(negedge clk); #1;
    check("e_wr", {31'd0, fifo_wr}, 32'd0);
    check("e_seq", {16'd0, seq_num}, 32'd0);
    for (int n = 0; n < 8; n++) send_pair(8'(n), 8'(8'h80 + n), 1'b1, 1'b0);
    drain();
    if (wlog.size() >= 1) check("e_hdr", wlog[0], 32'hA5A50000);
    else check("e_count", wlog.size(), 32'd5);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      reset        = ($urandom_range(0, 499) == 0);
      sample_valid = ($urandom_range(0, 9) < 7);
      en           = ($urandom_range(0, 9) != 0);
      fifo_full    = ($urandom_range(0, 9) == 0);
      sample_i     = 8'($urandom);
      sample_q     = 8'($urandom);
    end
    @(posedge clk); #2 reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_frame_packer.md
Name: iq_frame_packer

Overview:
- Upstream feeder of the A2F FIFO (application-to-FT600 direction), clocked in the sample domain.
- Packs 8-bit I/Q sample pairs into 32-bit words, two pairs per word.
- Prefixes every frame of FRAME_WORDS payload words with a sync/sequence header, so the host can detect frame boundaries and lost frames.
- On FIFO overflow, drops whole frames rather than partial words, so the stream stays aligned.

Parameters:
- FRAME_WORDS, 1024: payload words per frame (power of two, ≥2).
- SYNC_WORD, 16'hA5A5: upper half of the header word.
- CNT_WIDTH, 16: width of seq_num and drop_count.

Ports:
- clk  in  1  sample clock; also the A2F FIFO write clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  capture enable; sampled only at frame start.
- sample_valid  in  1  sample_i/sample_q valid this cycle.
- sample_i  in  8  in-phase sample.
- sample_q  in  8  quadrature sample.
- fifo_full  in  1  FIFO cannot accept a write on the next cycle (almost-full, margin ≥1).
- fifo_wdata  out  32  FIFO write data.
- fifo_wr  out  1  FIFO write strobe.
- frame_active  out  1  high from header issue until the last pair of the frame.
- seq_num  out  CNT_WIDTH  sequence number of the current/next frame.
- drop_count  out  CNT_WIDTH  saturating count of dropped frames.

Behaviour:
- Reset (synchronous, active-high):
  - fifo_wr=0, fifo_wdata=0, frame_active=0, seq_num=0, drop_count=0.
  - State IDLE; pair counter and half-word holding register cleared.
  - Reset mid-frame discards the partial word; no header is emitted for the aborted frame.
- Pair/word counting: one "pair" is one sample_valid cycle. A frame is 2*FRAME_WORDS pairs. Pair counter width is clog2(2*FRAME_WORDS).
- Word format: {q1,i1,q0,i0}, where pair0 is the earlier pair (held) and pair1 is the later pair.
- Header format: {SYNC_WORD, seq_num}.
- Timing: all writes are registered. fifo_wr pulses one cycle after the triggering sample_valid, for exactly one cycle per word. fifo_full is evaluated in the triggering cycle.
- Input rate: sample_valid may be high every cycle. The header shares its slot with the first pair, so no backpressure toward the source exists or is needed.
- IDLE:
  - sample_valid & ~en: discard the pair, stay in IDLE.
  - sample_valid & en & ~fifo_full: write the header, hold pair0, frame_active=1, go to PAYLOAD.
  - sample_valid & en & fifo_full: write nothing, drop_count++, go to DROP (this pair counts as pair 1 of the frame).
- PAYLOAD:
  - Even pair: hold in the holding register.
  - Odd pair & ~fifo_full: write the payload word.
  - Odd pair & fifo_full: suppress the write, drop_count++, go to DROP. Words already written stay in the FIFO; the host detects the short frame via the next header.
  - Last pair of the frame: seq_num++ (wraps), frame_active=0, go to IDLE.
  - en is ignored while in PAYLOAD.
- DROP:
  - Discard pairs until the frame-boundary count is reached.
  - At the boundary: seq_num++ and go to IDLE. The dropped frame consumes a sequence number, so the host sees the gap.
  - frame_active=0 throughout DROP.
- drop_count saturates at all-ones; it increments once per dropped frame, never per word.
- Simultaneous events: a boundary and en low in the same cycle → IDLE, and the next frame is gated by en then.
- fifo_full deasserting while in DROP has no effect until the boundary.

Optional Feature:
- Macro: IQ_PACKER_TEST_PATTERN_EN.
- Defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, the captured i/q are replaced by an 8-bit ramp: i=ramp, q=~ramp. The ramp increments per pair and resets to 0 at each frame start.
  - Headers and drop behaviour are unchanged.
- Undefined: no test_mode port; raw samples always.

Decomposition:
- Shared package sdr_pkg:
  - state enum (IDLE, PAYLOAD, DROP);
  - SYNC_WORD default;
  - header field positions;
  - a clog2-style constant function.
- Sub-module iq_test_pattern_gen holds the ramp generator; it is instantiated only under IQ_PACKER_TEST_PATTERN_EN.
- The FSM, pair counter and packing stay in iq_frame_packer.

Test Plan:
- FRAME_WORDS=4, en=1, fifo_full=0, 16 consecutive pairs (i=n, q=0x80+n) → header 0xA5A50000, then 0x81018000, 0x83038202, 0x85058404, 0x87078606; next frame header 0xA5A50001.
- Same stimulus with fifo_full=1 for the cycle of the 3rd payload word → exactly 3 writes for frame 0 (header + 2 words), drop_count=1, no writes until the boundary; next header 0xA5A50001.
- fifo_full=1 on the first pair of a frame → zero writes for that frame, drop_count=1; next frame header carries seq 1.
- en low for 10 pairs, then high mid-stream → no writes while low; the first write is a header with seq 0, and payload starts with the pair that triggered it.
- Reset pulsed after 5 pairs of a frame → fifo_wr=0 the next cycle, seq_num=0; the next frame starts with header 0xA5A50000.
- With IQ_PACKER_TEST_PATTERN_EN and test_mode=1 → first payload word 0xFE01FF00.
